fifo_reader: RTL and testbench

- Consumer-side companion to the team's synchronous FIFO.
- Drives the FIFO's pull side and forwards words into a registered valid/ready stream, grouped into fixed-length bursts framed by out_last.
- Decouples downstream backpressure from the FIFO through a 2-entry skid buffer.
- Sits between the FIFO and any downstream sink: packer, bus master or scoreboard monitor.

---
 rtl/fifo_reader_pkg.sv | 11 +
 rtl/fifo_reader_skid.sv | 64 ++++++
 rtl/fifo_reader.sv | 70 +++++++
 tb/tb_fifo_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing helpers for the FIFO reader and its skid buffer.
package fifo_reader_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Pull counter must hold 0..burst_len-1 for any legal burst_len.
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order valid/ready buffer of {last, data}; the head entry drives
// the registered outputs directly.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int busw = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [busw-1:0] in_data,
  input  logic            in_last,
  output logic            in_room,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [busw-1:0] out_data,
  output logic            out_last
);

  logic            v1;
  logic [busw-1:0] d1;
  logic            l1;
  logic            pop;

  assign pop     = out_valid && out_ready;
  // Second slot empty means occupancy < 2; a pop frees a slot this edge.
  assign in_room = !v1 || pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      v1        <= 1'b0;
      d1        <= '0;
      l1        <= 1'b0;
    end else if (pop) begin
      if (v1) begin
        out_data <= d1;
        out_last <= l1;
        v1       <= in_valid;
        d1       <= in_data;
        l1       <= in_last;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= in_data;
          out_last <= in_last;
        end
      end
    end else if (in_valid) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_last  <= in_last;
      end else begin
        v1 <= 1'b1;
        d1 <= in_data;
        l1 <= in_last;
      end
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Pulls fixed-length bursts from a first-word fall-through FIFO into a
// registered valid/ready stream, with out_last marking each burst's end.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int busw      = 32,
  parameter int burst_len = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            fifo_empty,
  input  logic [busw-1:0] fifo_dataout,
  output logic            fifo_pull,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [busw-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic [31:0]     words_sent
);

  localparam int            CW       = cnt_w(burst_len);
  localparam logic [CW-1:0] LAST_IDX = CW'(burst_len - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          room;
  logic          last_pull;

  assign fifo_pull = (state == BURST) && !fifo_empty && room;
  assign last_pull = (cnt == LAST_IDX);
  assign busy      = (state == BURST) || out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      words_sent <= '0;
    end else begin
      case (state)
        IDLE: if (enable && !fifo_empty) begin
          state <= BURST;
          cnt   <= '0;
        end
        // Bursts never end early: an empty FIFO only stalls the pulls.
        BURST: if (fifo_pull) begin
          cnt <= cnt + 1'b1;
          if (last_pull) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (out_valid && out_ready) words_sent <= words_sent + 32'd1;
    end
  end

  fifo_reader_skid #(.busw(busw)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fifo_pull),
    .in_data   (fifo_dataout),
    .in_last   (last_pull),
    .in_room   (room),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a FIFO model feeds two instances (burst_len 8 and 1);
// the expected stream is the FIFO word order with last on every burst_len-th beat.
module tb_fifo_reader;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en[2], fe[2], pull[2], ov[2], ordy[2], ol[2], bsy[2];
  logic [BW-1:0] fd[2], od[2];
  logic [31:0]   ws[2];

  fifo_reader #(.busw(BW), .burst_len(8)) dut0 (
    .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(fe[0]), .fifo_dataout(fd[0]),
    .fifo_pull(pull[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .out_last(ol[0]), .busy(bsy[0]), .words_sent(ws[0]));

  fifo_reader #(.busw(BW), .burst_len(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(fe[1]), .fifo_dataout(fd[1]),
    .fifo_pull(pull[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .out_last(ol[1]), .busy(bsy[1]), .words_sent(ws[1]));

  always #5 clk = ~clk;

  // FIFO model and output monitor
  logic [BW-1:0] mem[2][1024];
  logic [BW-1:0] rxd[2][256];
  logic          rxl[2][256];
  logic [BW-1:0] hd[2];
  logic          hl[2], hold[2];
  int            wreq[2], rd[2], npull[2], pe_err[2], st_err[2], rxn[2];
  int            pcyc[2][64];
  int            cyc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      int r;
      r = rd[i];
      if (pull[i] && fe[i]) pe_err[i] <= pe_err[i] + 1;
      if (pull[i] && !fe[i]) begin
        r = r + 1;
        pcyc[i][npull[i] % 64] <= cyc;
        npull[i] <= npull[i] + 1;
      end
      rd[i] <= r;
      fe[i] <= (r == wreq[i]);
      fd[i] <= mem[i][r % 1024];
      if (rst) hold[i] <= 1'b0;
      else begin
        if (hold[i] && (!ov[i] || od[i] !== hd[i] || ol[i] !== hl[i])) st_err[i] <= st_err[i] + 1;
        hold[i] <= ov[i] && !ordy[i];
        hd[i]   <= od[i];
        hl[i]   <= ol[i];
        if (ov[i] && ordy[i]) begin
          rxd[i][rxn[i] % 256] <= od[i];
          rxl[i][rxn[i] % 256] <= ol[i];
          rxn[i] <= rxn[i] + 1;
        end
      end
    end
  end

  int total = 0, bad = 0;
  int sx = 0, ep = 0, eb = 0, wsbase = 0;

  task automatic push(input int i, input logic [BW-1:0] v);
    mem[i][wreq[i] % 1024] = v;
    wreq[i] = wreq[i] + 1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ov[i], ol[i], pull[i], bsy[i]} !== 4'b0) begin
        bad++; $display("FAIL reset_flags[%0d] got=%b want=0000", i, {ov[i], ol[i], pull[i], bsy[i]});
      end
      total++;
      if (od[i] !== '0) begin bad++; $display("FAIL reset_data[%0d] got=%h want=0", i, od[i]); end
      total++;
      if (ws[i] !== 32'd0) begin bad++; $display("FAIL reset_ws[%0d] got=%0d want=0", i, ws[i]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int s;
    s = rxn[0];
    ordy[0] = 1'b1;
    for (int k = 0; k < 8; k++) push(0, BW'(k));
    @(negedge clk);
    en[0] = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({pull[0], ov[0]} !== 2'b10) begin bad++; $display("FAIL basic_first_pull got pull/valid=%b want=10", {pull[0], ov[0]}); end
    en[0] = 1'b0;
    @(posedge clk); #1;
    total++;
    if (!ov[0] || od[0] !== '0) begin bad++; $display("FAIL basic_latency got valid=%b data=%h want 1/0", ov[0], od[0]); end
    for (int k = 0; k < 100 && rxn[0] - s < 8; k++) @(negedge clk);
    while (sx < rxn[0]) begin
      total++;
      if ({rxl[0][sx % 256], rxd[0][sx % 256]} !== {eb == 7, mem[0][ep % 1024]}) begin
        bad++; $display("FAIL basic_beat%0d got=%h want=%h", sx, {rxl[0][sx % 256], rxd[0][sx % 256]}, {eb == 7, mem[0][ep % 1024]});
      end
      sx++; ep++; eb = (eb + 1) % 8;
    end
    repeat (2) @(negedge clk);
    total++;
    if (ws[0] !== 32'(rxn[0] - wsbase) || rxn[0] - s != 8) begin
      bad++; $display("FAIL basic_count got ws=%0d beats=%0d want %0d/8", ws[0], rxn[0] - s, rxn[0] - wsbase);
    end
    total++;
    if (bsy[0] !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", bsy[0]); end
  endtask

  task automatic test_backpressure;
    int s;
    s = rxn[0];
    for (int k = 0; k < 8; k++) push(0, $urandom);
    @(negedge clk); en[0] = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    for (int k = 0; k < 100 && rxn[0] - s < 3; k++) @(negedge clk);
    ordy[0] = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({pull[0], ov[0]} !== 2'b01) begin bad++; $display("FAIL bp_stall got pull/valid=%b want=01", {pull[0], ov[0]}); end
    ordy[0] = 1'b1;
    for (int k = 0; k < 100 && rxn[0] - s < 8; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (rxn[0] - s != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", rxn[0] - s); end
    while (sx < rxn[0]) begin
      total++;
      if ({rxl[0][sx % 256], rxd[0][sx % 256]} !== {eb == 7, mem[0][ep % 1024]}) begin
        bad++; $display("FAIL bp_beat%0d got=%h want=%h", sx, {rxl[0][sx % 256], rxd[0][sx % 256]}, {eb == 7, mem[0][ep % 1024]});
      end
      sx++; ep++; eb = (eb + 1) % 8;
    end
    total++;
    if (st_err[0] != 0) begin bad++; $display("FAIL bp_hold_stable got=%0d want=0", st_err[0]); end
  endtask

  task automatic test_underflow;
    int s;
    s = rxn[0];
    for (int k = 0; k < 3; k++) push(0, $urandom);
    @(negedge clk); en[0] = 1'b1;
    @(negedge clk); en[0] = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (rxn[0] - s != 3 || !bsy[0]) begin bad++; $display("FAIL uf_partial got beats=%0d busy=%b want 3/1", rxn[0] - s, bsy[0]); end
    for (int k = 0; k < 5; k++) push(0, $urandom);
    for (int k = 0; k < 100 && rxn[0] - s < 8; k++) @(negedge clk);
    while (sx < rxn[0]) begin
      total++;
      if ({rxl[0][sx % 256], rxd[0][sx % 256]} !== {eb == 7, mem[0][ep % 1024]}) begin
        bad++; $display("FAIL uf_beat%0d got=%h want=%h", sx, {rxl[0][sx % 256], rxd[0][sx % 256]}, {eb == 7, mem[0][ep % 1024]});
      end
      sx++; ep++; eb = (eb + 1) % 8;
    end
    total++;
    if (pe_err[0] != 0 || rxn[0] - s != 8) begin bad++; $display("FAIL uf_pull_empty got errs=%0d beats=%0d want 0/8", pe_err[0], rxn[0] - s); end
  endtask

  task automatic test_enable_drop;
    int s, p;
    s = rxn[0]; p = npull[0];
    for (int k = 0; k < 16; k++) push(0, $urandom);
    @(negedge clk); en[0] = 1'b1;
    for (int k = 0; k < 50 && npull[0] - p < 2; k++) @(negedge clk);
    en[0] = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (npull[0] - p != 8 || wreq[0] - rd[0] != 8) begin
      bad++; $display("FAIL en_drop got pulls=%0d left=%0d want 8/8", npull[0] - p, wreq[0] - rd[0]);
    end
    total++;
    if (bsy[0] !== 1'b0 || rxn[0] - s != 8) begin bad++; $display("FAIL en_drop_idle got busy=%b beats=%0d want 0/8", bsy[0], rxn[0] - s); end
    while (sx < rxn[0]) begin
      total++;
      if ({rxl[0][sx % 256], rxd[0][sx % 256]} !== {eb == 7, mem[0][ep % 1024]}) begin
        bad++; $display("FAIL en_beat%0d got=%h want=%h", sx, {rxl[0][sx % 256], rxd[0][sx % 256]}, {eb == 7, mem[0][ep % 1024]});
      end
      sx++; ep++; eb = (eb + 1) % 8;
    end
  endtask

  task automatic test_reset_mid;
    int p;
    p = npull[0];
    ordy[0] = 1'b0; en[0] = 1'b1;
    for (int k = 0; k < 50 && npull[0] - p < 2; k++) @(negedge clk);
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    total++;
    if (npull[0] - p != 3 || !ov[0]) begin bad++; $display("FAIL rm_setup got pulls=%0d valid=%b want 3/1", npull[0] - p, ov[0]); end
    while (sx < rxn[0]) begin
      total++;
      if ({rxl[0][sx % 256], rxd[0][sx % 256]} !== {eb == 7, mem[0][ep % 1024]}) begin
        bad++; $display("FAIL rm_beat%0d got=%h want=%h", sx, {rxl[0][sx % 256], rxd[0][sx % 256]}, {eb == 7, mem[0][ep % 1024]});
      end
      sx++; ep++; eb = (eb + 1) % 8;
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({ov[0], ol[0], pull[0], bsy[0]} !== 4'b0 || ws[0] !== 32'd0) begin
      bad++; $display("FAIL rm_async got flags=%b ws=%0d want 0000/0", {ov[0], ol[0], pull[0], bsy[0]}, ws[0]);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    ep = rd[0]; eb = 0; sx = rxn[0]; wsbase = rxn[0];
    for (int k = 0; k < 3; k++) push(0, $urandom);
    ordy[0] = 1'b1;
    for (int k = 0; k < 100 && rxn[0] - sx < 8; k++) @(negedge clk);
    en[0] = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ws[0] !== 32'(rxn[0] - wsbase) || rxn[0] - sx != 8) begin
      bad++; $display("FAIL rm_count got ws=%0d beats=%0d want %0d/8", ws[0], rxn[0] - sx, rxn[0] - wsbase);
    end
    while (sx < rxn[0]) begin
      total++;
      if ({rxl[0][sx % 256], rxd[0][sx % 256]} !== {eb == 7, mem[0][ep % 1024]}) begin
        bad++; $display("FAIL rm_post_beat%0d got=%h want=%h", sx, {rxl[0][sx % 256], rxd[0][sx % 256]}, {eb == 7, mem[0][ep % 1024]});
      end
      sx++; ep++; eb = (eb + 1) % 8;
    end
  endtask

  task automatic test_back_to_back;
    int s, p;
    s = rxn[1]; p = npull[1];
    ordy[1] = 1'b1;
    for (int k = 0; k < 4; k++) push(1, $urandom);
    @(negedge clk); en[1] = 1'b1;
    for (int k = 0; k < 50 && rxn[1] - s < 4; k++) @(negedge clk);
    en[1] = 1'b0;
    total++;
    if (rxn[1] - s != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", rxn[1] - s); end
    for (int j = 0; j < 4; j++) begin
      total++;
      if ({rxl[1][(s + j) % 256], rxd[1][(s + j) % 256]} !== {1'b1, mem[1][j]}) begin
        bad++; $display("FAIL b2b_beat%0d got=%h want=%h", j, {rxl[1][(s + j) % 256], rxd[1][(s + j) % 256]}, {1'b1, mem[1][j]});
      end
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (pcyc[1][(p + j + 1) % 64] - pcyc[1][(p + j) % 64] != 2) begin
        bad++; $display("FAIL b2b_gap%0d got=%0d want=2", j, pcyc[1][(p + j + 1) % 64] - pcyc[1][(p + j) % 64]);
      end
    end
  endtask

  task automatic test_random;
    int s, np;
    s = rxn[0]; np = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      ordy[0] = 1'($urandom_range(0, 1));
      en[0]   = ($urandom_range(0, 3) == 0);
      if (np < 24 && $urandom_range(0, 2) == 0) begin push(0, $urandom); np++; end
    end
    @(negedge clk);
    while (np < 24) begin push(0, $urandom); np++; end
    en[0] = 1'b1; ordy[0] = 1'b1;
    for (int k = 0; k < 200 && rxn[0] - s < 24; k++) @(negedge clk);
    en[0] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (rxn[0] - s != 24 || ws[0] !== 32'(rxn[0] - wsbase)) begin
      bad++; $display("FAIL rnd_count got beats=%0d ws=%0d want 24/%0d", rxn[0] - s, ws[0], rxn[0] - wsbase);
    end
    while (sx < rxn[0]) begin
      total++;
      if ({rxl[0][sx % 256], rxd[0][sx % 256]} !== {eb == 7, mem[0][ep % 1024]}) begin
        bad++; $display("FAIL rnd_beat%0d got=%h want=%h", sx, {rxl[0][sx % 256], rxd[0][sx % 256]}, {eb == 7, mem[0][ep % 1024]});
      end
      sx++; ep++; eb = (eb + 1) % 8;
    end
    total++;
    if (st_err[0] != 0 || pe_err[0] != 0 || pe_err[1] != 0 || bsy[0] !== 1'b0) begin
      bad++; $display("FAIL rnd_protocol got hold=%0d empty_pulls=%0d/%0d busy=%b want 0/0/0/0", st_err[0], pe_err[0], pe_err[1], bsy[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin en[i] = 1'b0; ordy[i] = 1'b0; end
    test_reset;
    test_basic;
    test_backpressure;
    test_underflow;
    test_enable_drop;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
